// File: rtl/bcd_stopwatch_ctrl_if.sv
// Button, counter and display bus between the debounced buttons, the BCD
// counter and the stopwatch run-control sequencer.
interface bcd_stopwatch_ctrl_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       lap;
  logic [7:0] cnt_val;
  logic       cnt_x;
  logic       cnt_clr;
  logic [7:0] disp;
  logic       running;
  logic       lap_active;
  logic       done;

  modport master (
    output start, stop, clear, lap, cnt_val,
    input  cnt_x, cnt_clr, disp, running, lap_active, done
  );

  modport slave (
    input  start, stop, clear, lap, cnt_val,
    output cnt_x, cnt_clr, disp, running, lap_active, done
  );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch run-control sequencer: prescaled count ticks, counter clear, lap hold.
// Optional autostop at 99 (DONE state) is enabled by defining BCD_SW_AUTOSTOP_EN.
module bcd_stopwatch_ctrl #(
  parameter int unsigned PRESCALE = 1000
) (
  input logic                  clk,
  input logic                  reset,
  bcd_stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [7:0]    lap_reg;
  logic          cnt_x_q;
  logic          cnt_clr_q;
  logic          running_q;
  logic          lap_active_q;
`ifdef BCD_SW_AUTOSTOP_EN
  logic          done_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      presc        <= '0;
      cnt_x_q      <= 1'b0;
      cnt_clr_q    <= 1'b0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      lap_reg      <= '0;
`ifdef BCD_SW_AUTOSTOP_EN
      done_q       <= 1'b0;
`endif
    end else begin
      cnt_x_q   <= 1'b0;
      cnt_clr_q <= 1'b0;
      if (bus.clear) begin
        state        <= IDLE;
        presc        <= '0;
        running_q    <= 1'b0;
        lap_active_q <= 1'b0;
        // a clear held over several cycles still yields single-cycle pulses
        cnt_clr_q    <= ~cnt_clr_q;
`ifdef BCD_SW_AUTOSTOP_EN
        done_q       <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state     <= RUN;
              presc     <= '0;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (bus.stop) begin
              state     <= PAUSE;
              running_q <= 1'b0;
            end else begin
              if (presc == PRESC_MAX) begin
                presc <= '0;
`ifdef BCD_SW_AUTOSTOP_EN
                if (bus.cnt_val == 8'h99) begin
                  state     <= DONE;
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
                end else begin
                  cnt_x_q <= 1'b1;
                end
`else
                cnt_x_q <= 1'b1;
`endif
              end else begin
                presc <= presc + 1'b1;
              end
              // lap samples the pre-tick value since cnt_val updates only after cnt_x
              if (bus.lap) begin
                if (lap_active_q) begin
                  lap_active_q <= 1'b0;
                end else begin
                  lap_active_q <= 1'b1;
                  lap_reg      <= bus.cnt_val;
                end
              end
            end
          end
          PAUSE: begin
            if (bus.start) begin
              state     <= RUN;
              running_q <= 1'b1;
            end else if (bus.lap) begin
              lap_active_q <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.cnt_x      = cnt_x_q;
  assign bus.cnt_clr    = cnt_clr_q;
  assign bus.running    = running_q;
  assign bus.lap_active = lap_active_q;
  assign bus.disp       = lap_active_q ? lap_reg : bus.cnt_val;
`ifdef BCD_SW_AUTOSTOP_EN
  assign bus.done       = done_q;
`else
  assign bus.done       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: emulates the BCD counter, checks every cycle
// against a reference model, plus a vector table and directed corner sequences.
module tb_bcd_stopwatch_ctrl;

  localparam int unsigned PRESCALE = 4;

  logic clk = 1'b0;
  logic reset;

  bcd_stopwatch_ctrl_if bus ();

  bcd_stopwatch_ctrl #(.PRESCALE(PRESCALE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: tick on every PRESCALE-th active RUN edge
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mmode_t;
  mmode_t     m_mode = M_IDLE;
  int         m_run_edges = 0;
  bit         m_x = 1'b0;
  bit         m_clr = 1'b0;
  bit         m_lap = 1'b0;
  logic [7:0] m_lap_val = 8'h00;

  typedef struct {
    bit         rst, st, sp, cl, lp;
    bit         ex_x, ex_run;
    logic [7:0] ex_cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit st, bit ex_x, bit ex_run, logic [7:0] ex_cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = 1'b0; v.cl = 1'b0; v.lp = 1'b0;
    v.ex_x = ex_x; v.ex_run = ex_run; v.ex_cnt = ex_cnt;
    return v;
  endfunction

  function automatic logic [7:0] bcd_inc(logic [7:0] v);
    int n;
    logic [3:0] t, o;
    n = (int'(v[7:4]) * 10 + int'(v[3:0]) + 1) % 100;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input bit sp, input bit cl,
                            input bit lp, input logic [7:0] cv);
    bit clr_prev;
    clr_prev = m_clr;
    m_x   = 1'b0;
    m_clr = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_run_edges = 0; m_lap = 1'b0; m_lap_val = 8'h00;
    end else if (cl) begin
      m_mode = M_IDLE; m_run_edges = 0; m_lap = 1'b0; m_clr = !clr_prev;
    end else begin
      case (m_mode)
        M_IDLE: if (st) begin m_mode = M_RUN; m_run_edges = 0; end
        M_RUN: begin
          if (sp) m_mode = M_PAUSE;
          else begin
            m_run_edges++;
            if (m_run_edges % PRESCALE == 0) begin
`ifdef BCD_SW_AUTOSTOP_EN
              if (cv == 8'h99) m_mode = M_DONE;
              else m_x = 1'b1;
`else
              m_x = 1'b1;
`endif
            end
            if (lp) begin
              if (m_lap) m_lap = 1'b0;
              else begin m_lap = 1'b1; m_lap_val = cv; end
            end
          end
        end
        M_PAUSE: begin
          if (st) m_mode = M_RUN;
          else if (lp) m_lap = 1'b0;
        end
        default: begin end
      endcase
    end
  endtask

  // one clock: sample inputs, advance counter emulation and model, compare all outputs
  task automatic step();
    bit rst, st, sp, cl, lp, px, pclr;
    logic [7:0] cv;
    rst = reset; st = bus.start; sp = bus.stop; cl = bus.clear; lp = bus.lap;
    cv = bus.cnt_val; px = bus.cnt_x; pclr = bus.cnt_clr;
    @(posedge clk);
    #1;
    if (rst || pclr) bus.cnt_val = 8'h00;
    else if (px) bus.cnt_val = bcd_inc(cv);
    model_step(rst, st, sp, cl, lp, cv);
    reset = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
    #1;
    check("cnt_x", 8'(bus.cnt_x), 8'(m_x));
    check("cnt_clr", 8'(bus.cnt_clr), 8'(m_clr));
    check("running", 8'(bus.running), 8'(m_mode == M_RUN));
    check("lap_active", 8'(bus.lap_active), 8'(m_lap));
    check("done", 8'(bus.done), 8'(m_mode == M_DONE));
    check("disp", bus.disp, m_lap ? m_lap_val : bus.cnt_val);
  endtask

  // steps until cnt_x is seen; n = steps taken, or -1 if the budget expires
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 2 * PRESCALE + 2; i++) begin
      step();
      if (bus.cnt_x) begin n = i; break; end
    end
  endtask

  initial begin
    int n;
    int xs;
    reset = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
    bus.cnt_val = 8'h00;

    // reset, idle, start, then 20 cycles of free-running count
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00));
    for (int c = 2; c <= 21; c++)
      tbl.push_back(mk(1'b0, 1'b0, (c >= 5) && ((c - 5) % 4 == 0), 1'b1,
                       (c <= 5) ? 8'h00 : 8'((c - 6) / 4 + 1)));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; bus.start = tbl[i].st; bus.stop = tbl[i].sp;
      bus.clear = tbl[i].cl; bus.lap = tbl[i].lp;
      step();
      check("tbl_cnt_x", 8'(bus.cnt_x), 8'(tbl[i].ex_x));
      check("tbl_running", 8'(bus.running), 8'(tbl[i].ex_run));
      check("tbl_cnt_val", bus.cnt_val, tbl[i].ex_cnt);
    end

    // pause at prescaler 2, resume keeps the partial tick
    step(); step();
    bus.stop = 1'b1; step();
    check("pause_running", 8'(bus.running), 8'h00);
    xs = 0;
    for (int i = 0; i < 10; i++) begin step(); xs += int'(bus.cnt_x); end
    check("pause_no_tick", 8'(xs), 8'h00);
    bus.start = 1'b1; step();
    check("resume_running", 8'(bus.running), 8'h01);
    wait_tick(n);
    check("resume_gap", 8'(n), 8'h02);
    wait_tick(n);
    check("tick_spacing", 8'(n), 8'(PRESCALE));

    // lap hold at 07 across three ticks, release shows 10
    bus.clear = 1'b1; step(); step();
    check("clear_cnt", bus.cnt_val, 8'h00);
    bus.cnt_val = 8'h07;
    bus.start = 1'b1; step();
    bus.lap = 1'b1; step();
    check("lap_hold", 8'(bus.lap_active), 8'h01);
    check("lap_disp", bus.disp, 8'h07);
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      check("lap_tick_seen", 8'(n > 0), 8'h01);
      check("lap_disp_frozen", bus.disp, 8'h07);
    end
    step();
    check("lap_cnt_advanced", bus.cnt_val, 8'h10);
    bus.lap = 1'b1; step();
    check("lap_release", 8'(bus.lap_active), 8'h00);
    check("lap_release_disp", bus.disp, 8'h10);

    // clear and stop together while a lap is held
    bus.lap = 1'b1; step();
    check("lap_held_again", 8'(bus.lap_active), 8'h01);
    bus.clear = 1'b1; bus.stop = 1'b1; step();
    check("cs_running", 8'(bus.running), 8'h00);
    check("cs_cnt_clr", 8'(bus.cnt_clr), 8'h01);
    check("cs_lap", 8'(bus.lap_active), 8'h00);
    step();
    check("cs_clr_once", 8'(bus.cnt_clr), 8'h00);
    check("cs_cnt_val", bus.cnt_val, 8'h00);

    // count through 99
    bus.cnt_val = 8'h95;
    bus.start = 1'b1; step();
    for (int i = 0; i < 4; i++) wait_tick(n);
    step();
    check("at_99", bus.cnt_val, 8'h99);
`ifdef BCD_SW_AUTOSTOP_EN
    xs = 0;
    for (int i = 0; i < 2 * PRESCALE && !bus.done; i++) begin step(); xs += int'(bus.cnt_x); end
    check("as_done", 8'(bus.done), 8'h01);
    check("as_no_tick", 8'(xs), 8'h00);
    bus.start = 1'b1; step();
    check("as_start_ignored", 8'(bus.running), 8'h00);
    check("as_hold_99", bus.cnt_val, 8'h99);
    bus.clear = 1'b1; step();
    check("as_clear_done", 8'(bus.done), 8'h00);
    step();
    check("as_clear_cnt", bus.cnt_val, 8'h00);
`else
    wait_tick(n);
    check("wrap_tick", 8'(n > 0), 8'h01);
    step();
    check("wrap_cnt", bus.cnt_val, 8'h00);
`endif

    // reset in RUN at prescaler 3 with start present
    bus.clear = 1'b1; step(); step();
    bus.start = 1'b1; step();
    step(); step(); step();
    reset = 1'b1; bus.start = 1'b1; step();
    check("rst_running", 8'(bus.running), 8'h00);
    check("rst_cnt_x", 8'(bus.cnt_x), 8'h00);
    check("rst_lap", 8'(bus.lap_active), 8'h00);
    check("rst_cnt_val", bus.cnt_val, 8'h00);
    step();
    check("rst_idle_running", 8'(bus.running), 8'h00);
    check("rst_idle_cnt_x", 8'(bus.cnt_x), 8'h00);

    // randomized pulses against the model
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 149) == 0);
      bus.start = ($urandom_range(0, 5) == 0);
      bus.stop  = ($urandom_range(0, 11) == 0);
      bus.clear = ($urandom_range(0, 29) == 0);
      bus.lap   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) bus.cnt_val = 8'h97;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
